// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared PIDs, packet widths, tx kinds and protocol states
package usb_pkg;

  localparam int TOKEN_W   = 19;
  localparam int DATA_W    = 72;
  localparam int PAYLOAD_W = 64;

  // PIDs in the bit-reversed form used throughout the codebase
  localparam logic [7:0] OUTPID  = 8'b10000111;
  localparam logic [7:0] INPID   = 8'b10010110;
  localparam logic [7:0] DATAPID = 8'b11000011;
  localparam logic [7:0] ACKPID  = 8'b01001011;
  localparam logic [7:0] NAKPID  = 8'b01011010;

  typedef enum logic [1:0] {
    TX_TOKEN  = 2'd0,
    TX_DATA   = 2'd1,
    TX_HSHAKE = 2'd2
  } tx_kind_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_TOK,
    S_WAIT_TOK,
    S_SEND_DAT,
    S_WAIT_DAT,
    S_WAIT_HS,
    S_WAIT_RXD,
    S_SEND_HS,
    S_WAIT_HST,
    S_RETRY,
    S_SUCCESS,
    S_FAIL
  } ptcl_state_e;

endpackage

// File: rtl/usb_protocol_fsm_if.sv
// rtl/usb_protocol_fsm_if.sv - request, encoder and decoder signals of the protocol stage
interface usb_protocol_fsm_if;
  import usb_pkg::*;

  logic [TOKEN_W-1:0]   token_pkt;
  logic [DATA_W-1:0]    data_pkt;
  logic                 data_avail;
  logic                 ptcl_ready;
  logic                 ptcl_done;
  logic                 ptcl_success;
  logic [PAYLOAD_W-1:0] ptcl_data;
  logic [DATA_W-1:0]    tx_pkt;
  tx_kind_e             tx_kind;
  logic                 tx_start;
  logic                 tx_done;
  logic                 rx_valid;
  logic [7:0]           rx_pid;
  logic [PAYLOAD_W-1:0] rx_data;
  logic                 rx_crc_ok;

  modport slave (
    input  token_pkt, data_pkt, data_avail, tx_done, rx_valid, rx_pid, rx_data, rx_crc_ok,
    output ptcl_ready, ptcl_done, ptcl_success, ptcl_data, tx_pkt, tx_kind, tx_start
  );

  modport master (
    output token_pkt, data_pkt, data_avail, tx_done, rx_valid, rx_pid, rx_data, rx_crc_ok,
    input  ptcl_ready, ptcl_done, ptcl_success, ptcl_data, tx_pkt, tx_kind, tx_start
  );

endinterface

// File: rtl/ptcl_timer.sv
// rtl/ptcl_timer.sv - response timeout counter, expires on its TIMEOUT_CYC-th enabled cycle
module ptcl_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expired = i_en && (r_cnt == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/usb_protocol_fsm.sv
// rtl/usb_protocol_fsm.sv - token/data/handshake sequencing with bounded retry
// Optional PTCL_DEBUG_EN adds o_attempts (attempt count of the last finished transaction).
module usb_protocol_fsm
  import usb_pkg::*;
#(
  parameter int MAX_RETRY   = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  usb_protocol_fsm_if.slave io_bus
`ifdef PTCL_DEBUG_EN
  ,
  output logic [3:0]        o_attempts
`endif
);

  ptcl_state_e          r_state;
  ptcl_state_e          w_next;
  logic [TOKEN_W-1:0]   r_token;
  logic [DATA_W-1:0]    r_data;
  logic                 r_is_in;
  logic                 r_hs_ack;
  logic [3:0]           r_retry_cnt;
  logic [PAYLOAD_W-1:0] r_rx_buf;
  logic [PAYLOAD_W-1:0] r_ptcl_data;

  logic [7:0]           w_tok_pid;
  logic                 w_pid_out;
  logic                 w_pid_in;
  logic                 w_tmr_en;
  logic                 w_tmr_expired;
  logic                 w_last_try;
  logic                 w_rx_good;
  logic                 w_tx_start;
  tx_kind_e             w_tx_kind;
  logic [DATA_W-1:0]    w_tx_pkt;

  assign w_tok_pid  = io_bus.token_pkt[TOKEN_W-1 -: 8];
  assign w_pid_out  = (w_tok_pid == OUTPID);
  assign w_pid_in   = (w_tok_pid == INPID);
  assign w_tmr_en   = (r_state == S_WAIT_HS) || (r_state == S_WAIT_RXD);
  assign w_last_try = ((r_retry_cnt + 4'd1) == 4'(MAX_RETRY));
  assign w_rx_good  = (io_bus.rx_pid == DATAPID) && io_bus.rx_crc_ok;

  // Counter is held clear outside the two response-wait states, so every entry starts at zero
  ptcl_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk       (clk),
    .rst_b     (rst_b),
    .i_clr     (!w_tmr_en),
    .i_en      (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    w_tx_kind  = TX_TOKEN;
    w_tx_pkt   = '0;
    case (r_state)
      S_IDLE:     if (io_bus.data_avail) w_next = (w_pid_out || w_pid_in) ? S_SEND_TOK : S_FAIL;
      S_SEND_TOK: begin
        w_tx_start = 1'b1;
        w_tx_pkt   = {r_token, 53'b0};
        w_next     = S_WAIT_TOK;
      end
      S_WAIT_TOK: if (io_bus.tx_done) w_next = r_is_in ? S_WAIT_RXD : S_SEND_DAT;
      S_SEND_DAT: begin
        w_tx_start = 1'b1;
        w_tx_kind  = TX_DATA;
        w_tx_pkt   = r_data;
        w_next     = S_WAIT_DAT;
      end
      S_WAIT_DAT: if (io_bus.tx_done) w_next = S_WAIT_HS;
      S_WAIT_HS: begin
        if (io_bus.rx_valid) w_next = (io_bus.rx_pid == ACKPID) ? S_SUCCESS : S_RETRY;
        else if (w_tmr_expired) w_next = S_RETRY;
      end
      // A bad CRC is answered with NAK whatever the PID; a clean non-DATA0 packet is just dropped
      S_WAIT_RXD: begin
        if (io_bus.rx_valid) w_next = (w_rx_good || !io_bus.rx_crc_ok) ? S_SEND_HS : S_RETRY;
        else if (w_tmr_expired) w_next = S_RETRY;
      end
      S_SEND_HS: begin
        w_tx_start = 1'b1;
        w_tx_kind  = TX_HSHAKE;
        w_tx_pkt   = {(r_hs_ack ? ACKPID : NAKPID), 64'b0};
        w_next     = S_WAIT_HST;
      end
      S_WAIT_HST: if (io_bus.tx_done) w_next = r_hs_ack ? S_SUCCESS : S_RETRY;
      S_RETRY:    w_next = w_last_try ? S_FAIL : S_SEND_TOK;
      S_SUCCESS:  w_next = S_IDLE;
      S_FAIL:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_token     <= '0;
      r_data      <= '0;
      r_is_in     <= 1'b0;
      r_hs_ack    <= 1'b0;
      r_retry_cnt <= '0;
      r_rx_buf    <= '0;
      r_ptcl_data <= '0;
    end else begin
      if (r_state == S_IDLE && io_bus.data_avail) begin
        r_token     <= io_bus.token_pkt;
        r_data      <= io_bus.data_pkt;
        r_is_in     <= w_pid_in;
        r_retry_cnt <= '0;
      end
      if (r_state == S_RETRY) begin
        r_retry_cnt <= r_retry_cnt + 4'd1;
      end
      if (r_state == S_WAIT_RXD && io_bus.rx_valid) begin
        r_hs_ack <= w_rx_good;
        r_rx_buf <= io_bus.rx_data;
      end
      // Payload becomes visible only once the ACK for it has gone out
      if (r_state == S_WAIT_HST && io_bus.tx_done && r_hs_ack) begin
        r_ptcl_data <= r_rx_buf;
      end
    end
  end

`ifdef PTCL_DEBUG_EN
  logic [3:0] r_attempts;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_attempts <= '0;
    end else if (w_next == S_SUCCESS || w_next == S_FAIL) begin
      r_attempts <= (r_state == S_IDLE) ? 4'd0 : r_retry_cnt + 4'd1;
    end
  end

  assign o_attempts = r_attempts;
`endif

  assign io_bus.ptcl_ready   = (r_state == S_IDLE);
  assign io_bus.ptcl_done    = (r_state == S_SUCCESS) || (r_state == S_FAIL);
  assign io_bus.ptcl_success = (r_state == S_SUCCESS);
  assign io_bus.ptcl_data    = r_ptcl_data;
  assign io_bus.tx_start     = w_tx_start;
  assign io_bus.tx_kind      = w_tx_kind;
  assign io_bus.tx_pkt       = w_tx_pkt;

endmodule

// File: doc/usb_protocol_fsm.md
Name: usb_protocol_fsm

Overview:
- Protocol stage directly downstream of the read/write FSM.
- Accepts one token packet plus an optional data packet per transaction. Sequences the bus exchange through the packet encoder and decoder, handles ACK/NAK/timeout with bounded retry, and returns a done/success pulse, plus read data on IN transactions.
- Owns no bit-level work: CRC, bit stuffing and NRZI belong to the encoder/decoder.

Parameters:
- MAX_RETRY, 8, total attempts per transaction before failure (range 1..15).
- TIMEOUT_CYC, 255, cycles waited for a response packet before the attempt is declared lost (range 1..255).

Ports:
- clk  in  1  clock
- rst_b  in  1  reset
- token_pkt  in  19  {PID[7:0], ADDR[6:0], ENDP[3:0]}; PID bit-reversed codebase form
- data_pkt  in  72  {DATA0 PID[7:0], payload[63:0]}; payload already bit-reversed
- data_avail  in  1  request valid
- ptcl_ready  out  1  idle, will accept request
- ptcl_done  out  1  one-cycle pulse, transaction finished
- ptcl_success  out  1  valid with ptcl_done
- ptcl_data  out  64  IN payload; valid with ptcl_done && ptcl_success, held until next success
- tx_pkt  out  72  packet to encoder, left-justified
- tx_kind  out  2  0 token, 1 data, 2 handshake
- tx_start  out  1  one-cycle launch pulse
- tx_done  in  1  encoder one-cycle pulse, packet fully sent
- rx_valid  in  1  decoder one-cycle pulse, packet received
- rx_pid  in  8  received PID
- rx_data  in  64  received payload
- rx_crc_ok  in  1  CRC check result, valid with rx_valid

Behaviour:
- Reset and clock: rst_b asynchronous active-low, clk rising edge. Reset values:
  - state IDLE, all counters 0.
  - ptcl_ready 1; ptcl_done, ptcl_success, tx_start 0.
  - ptcl_data, tx_pkt, tx_kind 0.
- Reset mid-transaction aborts immediately. No done pulse is issued.
- Accept rule: in IDLE with data_avail=1, latch token_pkt/data_pkt, clear retry and timeout counts, go to SEND_TOK. ptcl_ready is 0 in every state except IDLE.
- Direction is decoded from the latched PID: OUT=8'b10000111, IN=8'b10010110. Any other PID gives done with success=0 the cycle after accept, and no bus traffic.
- States:
  - IDLE
  - SEND_TOK: tx_start=1 for one cycle, tx_kind=0, tx_pkt={token,53'b0}, then go to WAIT_TOK.
  - WAIT_TOK, on tx_done: OUT goes to SEND_DAT; IN goes to WAIT_RXD.
  - SEND_DAT: tx_start=1, tx_kind=1, tx_pkt=data_pkt, then go to WAIT_DAT.
  - WAIT_DAT, on tx_done: go to WAIT_HS.
  - WAIT_HS:
    - rx_valid with pid ACK=8'b01001011 gives SUCCESS.
    - NAK=8'b01011010, any other pid, or timeout gives RETRY.
  - WAIT_RXD:
    - rx_valid, pid DATA0=8'b11000011 and rx_crc_ok=1: latch rx_data, go to SEND_HS with ACK.
    - rx_valid with crc bad: go to SEND_HS with NAK.
    - other pid or timeout: go to RETRY.
  - SEND_HS: tx_start=1, tx_kind=2, tx_pkt={pid,64'b0}, then go to WAIT_HST.
  - WAIT_HST, on tx_done: ACK was sent gives SUCCESS; NAK was sent gives RETRY.
  - RETRY:
    - Increment the attempt count.
    - If count==MAX_RETRY, go to FAIL; else go to SEND_TOK, with timeout cleared.
  - SUCCESS: ptcl_done=1, ptcl_success=1 for one cycle; ptcl_data updated. Then IDLE.
  - FAIL: ptcl_done=1, ptcl_success=0 for one cycle. Then IDLE.
- Timeout: 8-bit counter.
  - Counts only in WAIT_HS and WAIT_RXD; cleared on entering either state.
  - Timeout fires when the count equals TIMEOUT_CYC-1 with no rx_valid that cycle. rx_valid in the same cycle wins.
- Spurious inputs: rx_valid outside WAIT_HS/WAIT_RXD is ignored. tx_done outside WAIT_* is ignored.
- Latency: min OUT transaction = accept + token + data + handshake. Done asserts 1 cycle after the ACK rx_valid.
- Inputs token_pkt/data_pkt may change after accept without effect.
- Back-to-back: IDLE samples data_avail in the cycle after the done pulse.

Optional Feature:
- Macro PTCL_DEBUG_EN.
- When defined: adds output port attempts, 4 bits. It holds the attempt count of the most recent finished transaction (1..MAX_RETRY), is updated with ptcl_done, and resets to 0.
- When undefined: the port and its register are absent; function is otherwise identical.

Decomposition:
- Package usb_pkg holds:
  - PID constants OUTPID, INPID, DATAPID, ACKPID, NAKPID.
  - tx_kind enum {TX_TOKEN, TX_DATA, TX_HSHAKE}.
  - State enum.
  - Token/data packet widths, 19 and 72.
- One sub-module, ptcl_timer: timeout counter with clear/enable/expired.

Test Plan:
- OUT, addr/endp 4, ACK after 3 cycles:
  - exactly 2 tx_start pulses (kinds 0 then 1);
  - ptcl_done && ptcl_success one cycle after rx_valid;
  - ptcl_ready back to 1 the next cycle.
- OUT, NAK twice then ACK: 3 token sends, done success; attempts=3 with PTCL_DEBUG_EN.
- IN, decoder returns DATA0 payload 64'hDEADBEEF_01234567 with CRC ok:
  - ACK handshake sent (tx_kind=2, tx_pkt[71:64]=8'b01001011);
  - ptcl_data=64'hDEADBEEF_01234567 at done; success=1.
- IN, CRC bad every attempt: 8 NAK handshakes, then done with success=0; ptcl_data unchanged from prior value.
- OUT with no response: each attempt waits 255 cycles. After 8 attempts, failure done. No rx_valid for the whole test; spurious rx_valid while in IDLE is ignored.
- Reset asserted in WAIT_HS: outputs return to reset values immediately, no done pulse; a new request after release completes normally.
